// File: rtl/quad_step_emitter_if.sv
// Command and output bundle for the quadrature step emitter.
// The master side issues move commands and observes the quadrature outputs;
// the slave side is the emitter itself.
interface quad_step_emitter_if #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_period;
    logic             cmd_abort;
    logic             qa;
    logic             qb;
    logic             step_pulse;
    logic             dir;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pos;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_abort,
        input  cmd_ready, qa, qb, step_pulse, dir, busy, done, pos
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_abort,
        output cmd_ready, qa, qb, step_pulse, dir, busy, done, pos
    );
endinterface

// File: rtl/quad_step_emitter.sv
// Quadrature step transmitter: accepts a move command (direction, step count,
// step period) and walks the (qa,qb) Gray sequence one phase per step, keeping
// a wrap-around position count. Phase and position persist across moves so a
// new move always continues from where the previous one stopped.
module quad_step_emitter #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    quad_step_emitter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             qa_r, qa_nxt;
    logic             qb_r, qb_nxt;
    logic [CNT_W-1:0] pos_r, pos_nxt;
    logic             dir_r, dir_nxt;
    logic [CNT_W-1:0] rem_r, rem_nxt;
    logic [DIV_W-1:0] div_r, div_nxt;
    logic [DIV_W-1:0] per_r, per_nxt;
    logic             step_r, step_nxt;
    logic             done_r, done_nxt;

    // Next (qa,qb) one phase along the sequence 00->10->11->01 (up) or its
    // reverse (down); only one bit ever changes.
    function automatic logic [1:0] gray_next(input logic [1:0] ab, input logic up);
        if (up)
            return {~ab[0], ab[1]};
        else
            return {ab[0], ~ab[1]};
    endfunction

    // A period of 0 behaves like 1, so the divider reload value saturates at 0.
    function automatic logic [DIV_W-1:0] period_reload(input logic [DIV_W-1:0] p);
        if (p == '0)
            return '0;
        else
            return p - DIV_W'(1);
    endfunction

    // State and datapath registers; everything clears on asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            qa_r   <= 1'b0;
            qb_r   <= 1'b0;
            pos_r  <= '0;
            dir_r  <= 1'b0;
            rem_r  <= '0;
            div_r  <= '0;
            per_r  <= '0;
            step_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            qa_r   <= qa_nxt;
            qb_r   <= qb_nxt;
            pos_r  <= pos_nxt;
            dir_r  <= dir_nxt;
            rem_r  <= rem_nxt;
            div_r  <= div_nxt;
            per_r  <= per_nxt;
            step_r <= step_nxt;
            done_r <= done_nxt;
        end
    end

    // Command acceptance, step timing, abort and completion decisions.
    always_comb begin
        logic [1:0] ab_adv;

        state_nxt = state;
        qa_nxt    = qa_r;
        qb_nxt    = qb_r;
        pos_nxt   = pos_r;
        dir_nxt   = dir_r;
        rem_nxt   = rem_r;
        div_nxt   = div_r;
        per_nxt   = per_r;
        step_nxt  = 1'b0;
        done_nxt  = 1'b0;
        ab_adv    = gray_next({qa_r, qb_r}, dir_r);

        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    dir_nxt = bus.cmd_dir;
                    rem_nxt = bus.cmd_steps;
                    per_nxt = period_reload(bus.cmd_period);
                    div_nxt = period_reload(bus.cmd_period);
                    // An empty move completes immediately without touching the phase.
                    if (bus.cmd_steps == '0)
                        done_nxt = 1'b1;
                    else
                        state_nxt = RUN;
                end
            end
            RUN: begin
                // Abort wins over a step that would otherwise fall on this edge.
                if (bus.cmd_abort) begin
                    state_nxt = IDLE;
                end else if (div_r != '0) begin
                    div_nxt = div_r - DIV_W'(1);
                end else begin
                    qa_nxt   = ab_adv[1];
                    qb_nxt   = ab_adv[0];
                    pos_nxt  = dir_r ? pos_r + CNT_W'(1) : pos_r - CNT_W'(1);
                    rem_nxt  = rem_r - CNT_W'(1);
                    div_nxt  = per_r;
                    step_nxt = 1'b1;
                    if (rem_r == CNT_W'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.busy       = (state == RUN);
    assign bus.qa         = qa_r;
    assign bus.qb         = qb_r;
    assign bus.pos        = pos_r;
    assign bus.dir        = dir_r;
    assign bus.step_pulse = step_r;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_quad_step_emitter.sv
// Bench for quad_step_emitter: a table of move commands with hand-derived end
// states, a scoreboard of expected step/done events with their cycle numbers,
// and hand-written sequences for held-valid while busy and reset mid-move.
module tb_quad_step_emitter;
    localparam int CNT_W = 8;
    localparam int DIV_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    quad_step_emitter_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();
    quad_step_emitter #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int               cyc;
        logic             sp;
        logic             qa;
        logic             qb;
        logic [CNT_W-1:0] pos;
        logic             dn;
    } ev_t;

    typedef struct {
        logic             dir;
        int               steps;
        int               period;
        int               abort_after;
        logic [CNT_W-1:0] exp_pos;
        logic [1:0]       exp_ab;
    } vec_t;

    ev_t              sb[$];
    vec_t             vecs[9];
    int               n_chk = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               midx = 0;
    logic [CNT_W-1:0] mpos = '0;
    logic [1:0]       seq[4];
    logic [1:0]       prev_ab = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called once per falling edge: Gray property, scoreboard, busy/ready agreement.
    task automatic monitor();
        ev_t e;
        logic [1:0] ab;
        ab = {bus.qa, bus.qb};
        if (ab !== prev_ab)
            chk("gray_single_bit_change", (ab ^ prev_ab) == 2'b11, 0);
        prev_ab = ab;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missed_event_cycle", cyc, e.cyc);
        end
        if (bus.step_pulse || bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_step_or_done", {bus.step_pulse, bus.done}, 0);
            end else begin
                e = sb.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("step_pulse", bus.step_pulse, e.sp);
                chk("qa", bus.qa, e.qa);
                chk("qb", bus.qb, e.qb);
                chk("pos", bus.pos, e.pos);
                chk("done", bus.done, e.dn);
            end
        end
        chk("busy_vs_ready", bus.busy, !bus.cmd_ready);
    endtask

    // Expected step/done events for a command driven while cyc == c.
    task automatic push_cmd(input logic d, input int steps, input int period,
                            input int abort_after, input int c);
        ev_t e;
        int p, n;
        p = (period == 0) ? 1 : period;
        if (steps == 0) begin
            e = '{c + 1, 1'b0, seq[midx][1], seq[midx][0], mpos, 1'b1};
            sb.push_back(e);
        end
        n = (abort_after >= 0) ? abort_after : steps;
        for (int i = 0; i < n; i++) begin
            midx = d ? (midx + 1) % 4 : (midx + 3) % 4;
            mpos = d ? mpos + 8'd1 : mpos - 8'd1;
            e = '{c + 1 + (i + 1) * p, 1'b1, seq[midx][1], seq[midx][0], mpos,
                  (abort_after < 0) && (i == steps - 1)};
            sb.push_back(e);
        end
    endtask

    task automatic drive_cmd(input logic d, input int steps, input int period);
        bus.cmd_valid  = 1'b1;
        bus.cmd_dir    = d;
        bus.cmd_steps  = CNT_W'(steps);
        bus.cmd_period = DIV_W'(period);
    endtask

    // Runs one table entry; entered and left on a falling edge.
    task automatic run_cmd(input vec_t v);
        int c, p, target, guard;
        p = (v.period == 0) ? 1 : v.period;
        chk("ready_before_cmd", bus.cmd_ready, 1);
        drive_cmd(v.dir, v.steps, v.period);
        c = cyc;
        push_cmd(v.dir, v.steps, v.period, v.abort_after, c);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        if (v.abort_after >= 0) begin
            target = c + 1 + v.abort_after * p;
            while (cyc < target) begin
                @(negedge clk);
                monitor();
            end
            bus.cmd_abort = 1'b1;
            @(posedge clk);
            #1 bus.cmd_abort = 1'b0;
        end
        guard = 0;
        do begin
            @(negedge clk);
            monitor();
            guard++;
        end while (!(bus.cmd_ready && sb.size() == 0) && guard < 3000);
        if (guard >= 3000) chk("move_timeout", 0, 1);
        chk("final_pos", bus.pos, v.exp_pos);
        chk("final_phase", {bus.qa, bus.qb}, v.exp_ab);
        chk("final_dir", bus.dir, v.dir);
        chk("final_busy", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        //             dir   steps per abort pos     phase
        vecs[0] = '{1'b1, 4, 3, -1, 8'd4,   2'b00};
        vecs[1] = '{1'b0, 4, 1, -1, 8'd0,   2'b00};
        vecs[2] = '{1'b0, 2, 1, -1, 8'd254, 2'b11};
        vecs[3] = '{1'b1, 0, 5, -1, 8'd254, 2'b11};
        vecs[4] = '{1'b1, 3, 0, -1, 8'd1,   2'b10};
        vecs[5] = '{1'b1, 5, 4,  2, 8'd3,   2'b01};
        vecs[6] = '{1'b1, 1, 2, -1, 8'd4,   2'b00};
        vecs[7] = '{1'b0, 3, 1,  1, 8'd3,   2'b01};
        vecs[8] = '{1'b1, 2, 2, -1, 8'd5,   2'b10};

        bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_steps = '0;
        bus.cmd_period = '0; bus.cmd_abort = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_qa", bus.qa, 0);
        chk("reset_qb", bus.qb, 0);
        chk("reset_pos", bus.pos, 0);
        chk("reset_ready", bus.cmd_ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_step_pulse", bus.step_pulse, 0);
        @(negedge clk);
        monitor();

        // Table of moves, issued back to back
        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

        // cmd_valid held high with changed inputs while busy: no re-accept
        drive_cmd(1'b1, 2, 3);
        c = cyc;
        push_cmd(1'b1, 2, 3, -1, c);
        @(posedge clk);
        #1;
        bus.cmd_steps = 8'd7; bus.cmd_dir = 1'b0; bus.cmd_period = 8'd1;
        while (cyc < c + 6) begin
            @(negedge clk);
            monitor();
        end
        bus.cmd_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            monitor();
        end
        chk("held_valid_queue_empty", sb.size(), 0);
        chk("held_valid_pos", bus.pos, 8'd7);
        chk("held_valid_phase", {bus.qa, bus.qb}, 2'b01);

        // Reset asserted mid-move forces reset values immediately
        drive_cmd(1'b1, 6, 2);
        c = cyc;
        push_cmd(1'b1, 6, 2, -1, c);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        while (cyc < c + 5) begin
            @(negedge clk);
            monitor();
        end
        #2 rst = 1'b1;
        #1;
        chk("midreset_qa", bus.qa, 0);
        chk("midreset_qb", bus.qb, 0);
        chk("midreset_pos", bus.pos, 0);
        chk("midreset_dir", bus.dir, 0);
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_ready", bus.cmd_ready, 1);
        chk("midreset_step_pulse", bus.step_pulse, 0);
        sb.delete();
        midx = 0;
        mpos = '0;
        prev_ab = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            monitor();
        end
        chk("after_reset_idle", bus.busy, 0);
        chk("after_reset_pos", bus.pos, 0);
        run_cmd('{1'b1, 1, 1, -1, 8'd1, 2'b10});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
